skullfet_tester: RTL and testbench

SKULLFET_TESTER -- requirements
Module: skullfet_tester

---
 rtl/skullfet_tester.sv | 151 +++++++++++++++
 tb/tb_skullfet_tester.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/skullfet_tester.sv
// Inverter tester for a SkullFET standard cell: drives an alternating stimulus,
// waits a settle window, samples the synchronized response and tallies pass/fail.
module skullfet_tester #(
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_tests,
  input  logic [3:0]       settle,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail,
  output logic             first_fail_vld
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       MIN_S   = 4'd3;

  state_t           state;
  logic             y_meta;
  logic             y_sync;
  logic [CNT_W-1:0] index;
  logic [CNT_W-1:0] num_cap;
  logic [3:0]       settle_cap;
  logic [3:0]       settle_cnt;

  logic [3:0]       settle_eff;
  logic             last_test;
  logic             sample_ok;

  // The floor of three settle cycles covers the two synchronizer stages plus
  // one cycle of margin for the device itself.
  assign settle_eff = (settle < MIN_S) ? MIN_S : settle;
  assign last_test  = (index == (num_cap - ONE));
  assign sample_ok  = (y_sync == ~dut_a);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      y_meta <= 1'b0;
      y_sync <= 1'b0;
    end else begin
      y_meta <= dut_y;
      y_sync <= y_meta;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      dut_a          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      index          <= '0;
      num_cap        <= '0;
      settle_cap     <= '0;
      settle_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            index          <= '0;
            num_cap        <= num_tests;
            settle_cap     <= settle_eff;
            if (num_tests != '0) begin
              state <= DRIVE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              done  <= 1'b1;
            end
          end
        end

        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dut_a      <= index[0];
            settle_cnt <= settle_cap;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
            if (settle_cnt == 4'd1) state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (sample_ok) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + ONE;
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + ONE;
              if (!first_fail_vld) begin
                first_fail     <= index;
                first_fail_vld <= 1'b1;
              end
            end
            if (last_test) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index <= index + ONE;
              state <= DRIVE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skullfet_tester.sv
// Directed bench for skullfet_tester: good, stuck-at and aborted runs on a
// 16-bit instance, plus a stuck-at-1 run on a 4-bit instance.
module tb_skullfet_tester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_tests = '0;
  logic [3:0]  settle = '0;
  logic [1:0]  y_mode = 2'd0;
  logic        dut_y;
  logic        dut_a, busy, done, first_fail_vld;
  logic [15:0] pass_cnt, fail_cnt, first_fail;

  logic        start4 = 1'b0;
  logic [3:0]  num_tests4 = '0;
  logic [3:0]  settle4 = '0;
  logic        dut_a4, busy4, done4, first_fail_vld4;
  logic [3:0]  pass_cnt4, fail_cnt4, first_fail4;

  int checks = 0;
  int errors = 0;
  int cycles;

  always #5 clk = ~clk;

  // Mode 0: working inverter; mode 1: output stuck at 0; mode 2: stuck at 1.
  assign dut_y = (y_mode == 2'd0) ? ~dut_a : (y_mode == 2'd2);

  skullfet_tester #(.CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .num_tests(num_tests), .settle(settle), .dut_y(dut_y), .dut_a(dut_a),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld)
  );

  skullfet_tester #(.CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start4), .abort(1'b0),
    .num_tests(num_tests4), .settle(settle4), .dut_y(1'b1), .dut_a(dut_a4),
    .busy(busy4), .done(done4), .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4),
    .first_fail(first_fail4), .first_fail_vld(first_fail_vld4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic start_run(input logic [15:0] n, input logic [3:0] s);
    num_tests = n;
    settle    = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (busy === 1'b1 && c < 4000) begin
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dut_a", dut_a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_ffv", first_fail_vld, 0);
    rst = 1'b0;
    @(negedge clk);

    // Good inverter, 8 tests, S=5: 8*(5+2) busy cycles.
    y_mode = 2'd0;
    start_run(16'd8, 4'd5);
    check("good_busy_rise", busy, 1);
    count_busy(cycles);
    check("good_busy_len", cycles, 56);
    check("good_pass", pass_cnt, 8);
    check("good_fail", fail_cnt, 0);
    check("good_ffv", first_fail_vld, 0);
    check("good_done", done, 1);
    check("good_dut_a_hold", dut_a, 1);
    repeat (3) @(negedge clk);
    check("good_done_sticky", done, 1);

    // Output stuck at 0: even tests expect 1 and fail, odd tests pass.
    y_mode = 2'd1;
    start_run(16'd6, 4'd0);
    check("s0_done_clr", done, 0);
    count_busy(cycles);
    check("s0_busy_len", cycles, 30);
    check("s0_pass", pass_cnt, 3);
    check("s0_fail", fail_cnt, 3);
    check("s0_first", first_fail, 0);
    check("s0_ffv", first_fail_vld, 1);
    check("s0_done", done, 1);

    // Zero-length run: done next cycle, counters cleared, never busy.
    y_mode = 2'd0;
    start_run(16'd0, 4'd5);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_pass", pass_cnt, 0);
    check("zero_fail", fail_cnt, 0);
    check("zero_ffv", first_fail_vld, 0);
    check("zero_dut_a_hold", dut_a, 1);
    repeat (2) @(negedge clk);
    check("zero_busy_later", busy, 0);

    // 100 tests at S=4 (6 cycles each); test 10 settles during cycles 61..64.
    // Input changes mid-run must not shorten the run or the settle window.
    start_run(16'd100, 4'd4);
    num_tests = 16'd3;
    settle    = 4'd15;
    repeat (62) @(negedge clk);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass_cnt, 10);
    check("abort_fail", fail_cnt, 0);

    // Abort beats start while idle.
    num_tests = 16'd5;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    check("abort_start_done", done, 0);
    check("abort_start_pass", pass_cnt, 10);

    // Reset during test 4 of 20 (S=3, tests 5 cycles each, test 4 in 20..24).
    start_run(16'd20, 4'd0);
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_pass", pass_cnt, 0);
    check("mrst_dut_a", dut_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_done_after", done, 0);
    start_run(16'd2, 4'd0);
    count_busy(cycles);
    check("fresh_busy_len", cycles, 10);
    check("fresh_pass", pass_cnt, 2);
    check("fresh_done", done, 1);

    // 4-bit instance, output stuck at 1: even indices drive 0 and expect 1, so
    // the 8 even tests (0..14) pass and the 7 odd ones fail, first at index 1.
    num_tests4 = 4'd15;
    settle4    = 4'd3;
    start4     = 1'b1;
    @(negedge clk);
    start4     = 1'b0;
    num_tests4 = 4'd2;
    cycles = 0;
    while (busy4 === 1'b1 && cycles < 4000) begin
      cycles++;
      start4 = (cycles % 7 == 0);
      @(negedge clk);
    end
    start4 = 1'b0;
    check("w4_busy_len", cycles, 75);
    check("w4_pass", pass_cnt4, 8);
    check("w4_fail", fail_cnt4, 7);
    check("w4_first", first_fail4, 1);
    check("w4_ffv", first_fail_vld4, 1);
    check("w4_done", done4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
